// File: rtl/counter_updown_mod_pkg.sv
// Shared constants and helpers for the up/down modulo-N counter.
// Optional feature macro: COUNTER_SATURATE_EN (hold at the bounds instead of wrapping).
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned GRAY_W = 32;

  // Binary to reflected Gray code; callers truncate to their own width.
  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic bit modulus_ok(input int unsigned width, input int unsigned modulus);
    return (modulus >= 2) && (64'(modulus) <= (64'(1) << width));
  endfunction

  function automatic bit reset_ok(input int unsigned modulus, input int unsigned reset_value);
    return reset_value < modulus;
  endfunction

endpackage

// File: rtl/counter_updown_mod_if.sv
// Control/data bundle between the input panel and the counter.
// Optional feature macro: COUNTER_SATURATE_EN (no effect on this interface).
interface counter_updown_mod_if #(
  parameter int unsigned WIDTH = 3
);

  logic             input_enable_3;
  logic             input_up_4;
  logic             input_load_5;
  logic [WIDTH-1:0] input_data_6;
  logic [WIDTH-1:0] output_count_7;
  logic [WIDTH-1:0] output_gray_8;
  logic             output_wrap_9;

  modport master (
    output input_enable_3, input_up_4, input_load_5, input_data_6,
    input  output_count_7, output_gray_8, output_wrap_9
  );

  modport slave (
    input  input_enable_3, input_up_4, input_load_5, input_data_6,
    output output_count_7, output_gray_8, output_wrap_9
  );

endinterface

// File: rtl/counter_updown_mod_next_value.sv
// Combinational next-count for one enabled step, plus the wrap / saturation flag.
// Optional feature macro: COUNTER_SATURATE_EN (hold at the bound and flag instead of wrapping).
module counter_next_value
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MODULUS = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             enable,
  output logic [WIDTH-1:0] next,
  output logic             wrap
);

  localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MODULUS - 1);

  // One extra bit so MODULUS == 2**WIDTH still compares and steps cleanly.
  logic [WIDTH:0] ext;
  assign ext = {1'b0, count};

  always_comb begin
    next = count;
    wrap = 1'b0;
    if (enable) begin
      if (up == DIR_UP) begin
        if (ext == TOP) begin
          wrap = 1'b1;
`ifdef COUNTER_SATURATE_EN
          next = count;
`else
          next = '0;
`endif
        end else begin
          next = WIDTH'(ext + 1'b1);
        end
      end else begin
        if (ext == '0) begin
          wrap = 1'b1;
`ifdef COUNTER_SATURATE_EN
          next = count;
`else
          next = WIDTH'(TOP);
`endif
        end else begin
          next = WIDTH'(ext - 1'b1);
        end
      end
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised synchronous up/down modulo-N counter with load, wrap pulse and Gray output.
// Optional feature macro: COUNTER_SATURATE_EN (saturate at 0 / MODULUS-1, wrap flags blocked steps).
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned MODULUS     = 8,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic                input_clock1_1,
  input  logic                input_reset1_2,
  counter_updown_mod_if.slave bus
);

  generate
    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
      $error("counter_updown_mod: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (!reset_ok(MODULUS, RESET_VALUE)) begin : g_bad_reset
      $error("counter_updown_mod: RESET_VALUE must be below MODULUS");
    end
  endgenerate

  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP       = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] RESET_GRY = WIDTH'(bin2gray(GRAY_W'(RESET_VALUE)));

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;

  logic [WIDTH-1:0] step_next;
  logic             step_wrap;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count_d;
  logic             wrap_d;

  counter_next_value #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count  (count_q),
    .up     (bus.input_up_4),
    .enable (bus.input_enable_3),
    .next   (step_next),
    .wrap   (step_wrap)
  );

  // Out-of-range load values clamp to the top of the count range.
  assign load_value = ({1'b0, bus.input_data_6} >= MOD_EXT) ? TOP : bus.input_data_6;

  always_comb begin
    count_d = step_next;
    wrap_d  = step_wrap;
    if (bus.input_load_5) begin
      count_d = load_value;
      wrap_d  = 1'b0;
    end
  end

  // Gray is derived from the next count so both outputs change on the same edge.
  always_ff @(posedge input_clock1_1) begin
    if (input_reset1_2) begin
      count_q <= RESET_CNT;
      gray_q  <= RESET_GRY;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      gray_q  <= WIDTH'(bin2gray(GRAY_W'(count_d)));
      wrap_q  <= wrap_d;
    end
  end

  assign bus.output_count_7 = count_q;
  assign bus.output_gray_8  = gray_q;
  assign bus.output_wrap_9  = wrap_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed, table-driven bench for counter_updown_mod (MODULUS=8 and MODULUS=6 instances).
// Expectations follow COUNTER_SATURATE_EN when the macro is defined.
module tb_counter_updown_mod;

  typedef struct {
    logic       rst;
    logic       load;
    logic       en;
    logic       up;
    logic [2:0] data;
    logic [2:0] cnt;
    logic [2:0] gray;
    logic       wrap;
  } vec_t;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   total;
  int   bad;

  vec_t tbl[$];

  counter_updown_mod_if #(.WIDTH(3)) a_if ();
  counter_updown_mod_if #(.WIDTH(3)) b_if ();

  counter_updown_mod #(.WIDTH(3), .MODULUS(8), .RESET_VALUE(0)) dut_a (
    .input_clock1_1 (clk),
    .input_reset1_2 (rst_a),
    .bus            (a_if.slave)
  );

  counter_updown_mod #(.WIDTH(3), .MODULUS(6), .RESET_VALUE(0)) dut_b (
    .input_clock1_1 (clk),
    .input_reset1_2 (rst_b),
    .bus            (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic load, input logic en, input logic up,
                     input logic [2:0] data, input logic [2:0] cnt, input logic [2:0] gray,
                     input logic wrap);
    vec_t v;
    v.rst = rst; v.load = load; v.en = en; v.up = up; v.data = data;
    v.cnt = cnt; v.gray = gray; v.wrap = wrap;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_all();
    rst_a = 1'b0; a_if.input_load_5 = 1'b0; a_if.input_enable_3 = 1'b0;
    a_if.input_up_4 = 1'b0; a_if.input_data_6 = 3'd0;
    rst_b = 1'b0; b_if.input_load_5 = 1'b0; b_if.input_enable_3 = 1'b0;
    b_if.input_up_4 = 1'b0; b_if.input_data_6 = 3'd0;
  endtask

  // Drive one vector into the selected DUT, clock once, compare all three outputs.
  task automatic apply(input bit sel_b, input vec_t v, input string tag);
    idle_all();
    if (sel_b) begin
      rst_b = v.rst; b_if.input_load_5 = v.load; b_if.input_enable_3 = v.en;
      b_if.input_up_4 = v.up; b_if.input_data_6 = v.data;
    end else begin
      rst_a = v.rst; a_if.input_load_5 = v.load; a_if.input_enable_3 = v.en;
      a_if.input_up_4 = v.up; a_if.input_data_6 = v.data;
    end
    @(posedge clk);
    #1;
    if (sel_b) begin
      check({tag, ".count"}, int'(b_if.output_count_7), int'(v.cnt));
      check({tag, ".gray"},  int'(b_if.output_gray_8),  int'(v.gray));
      check({tag, ".wrap"},  int'(b_if.output_wrap_9),  int'(v.wrap));
    end else begin
      check({tag, ".count"}, int'(a_if.output_count_7), int'(v.cnt));
      check({tag, ".gray"},  int'(a_if.output_gray_8),  int'(v.gray));
      check({tag, ".wrap"},  int'(a_if.output_wrap_9),  int'(v.wrap));
    end
  endtask

  task automatic step_b(input logic rst, input logic load, input logic en, input logic up,
                        input logic [2:0] data, input logic [2:0] cnt, input logic [2:0] gray,
                        input logic wrap, input string tag);
    vec_t v;
    v.rst = rst; v.load = load; v.en = en; v.up = up; v.data = data;
    v.cnt = cnt; v.gray = gray; v.wrap = wrap;
    apply(1'b1, v, tag);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_all();

    // Reset for two cycles.
    add(1, 0, 0, 0, 3'd0, 3'd0, 3'b000, 0);
    add(1, 0, 0, 0, 3'd0, 3'd0, 3'b000, 0);
    // Count up through the top of the range.
    add(0, 0, 1, 1, 3'd0, 3'd1, 3'b001, 0);
    add(0, 0, 1, 1, 3'd0, 3'd2, 3'b011, 0);
    add(0, 0, 1, 1, 3'd0, 3'd3, 3'b010, 0);
    add(0, 0, 1, 1, 3'd0, 3'd4, 3'b110, 0);
    add(0, 0, 1, 1, 3'd0, 3'd5, 3'b111, 0);
    add(0, 0, 1, 1, 3'd0, 3'd6, 3'b101, 0);
    add(0, 0, 1, 1, 3'd0, 3'd7, 3'b100, 0);
`ifdef COUNTER_SATURATE_EN
    add(0, 0, 1, 1, 3'd0, 3'd7, 3'b100, 1);
    add(0, 0, 1, 1, 3'd0, 3'd7, 3'b100, 1);
    add(0, 0, 1, 1, 3'd0, 3'd7, 3'b100, 1);
`else
    add(0, 0, 1, 1, 3'd0, 3'd0, 3'b000, 1);
    add(0, 0, 1, 1, 3'd0, 3'd1, 3'b001, 0);
    add(0, 0, 1, 1, 3'd0, 3'd2, 3'b011, 0);
`endif
    // Load 2, then count down across zero.
    add(0, 1, 0, 0, 3'd2, 3'd2, 3'b011, 0);
    add(0, 0, 1, 0, 3'd0, 3'd1, 3'b001, 0);
    add(0, 0, 1, 0, 3'd0, 3'd0, 3'b000, 0);
`ifdef COUNTER_SATURATE_EN
    add(0, 0, 1, 0, 3'd0, 3'd0, 3'b000, 1);
`else
    add(0, 0, 1, 0, 3'd0, 3'd7, 3'b100, 1);
`endif
    // Reset beats load and enable.
    add(0, 1, 0, 0, 3'd4, 3'd4, 3'b110, 0);
    add(1, 1, 1, 1, 3'd6, 3'd0, 3'b000, 0);
    // Reset at the top bound clears what would be a wrap/saturation pulse.
    add(0, 1, 0, 0, 3'd7, 3'd7, 3'b100, 0);
    add(1, 0, 1, 1, 3'd0, 3'd0, 3'b000, 0);
    // Hold with enable low while direction toggles.
    add(0, 1, 0, 0, 3'd3, 3'd3, 3'b010, 0);
    add(0, 0, 0, 1, 3'd0, 3'd3, 3'b010, 0);
    add(0, 0, 0, 0, 3'd0, 3'd3, 3'b010, 0);
    add(0, 0, 0, 1, 3'd0, 3'd3, 3'b010, 0);
    add(0, 0, 0, 0, 3'd0, 3'd3, 3'b010, 0);
    add(0, 0, 0, 1, 3'd0, 3'd3, 3'b010, 0);
    // Load beats enable.
    add(0, 1, 1, 1, 3'd5, 3'd5, 3'b111, 0);
    // Up from 6 for three edges, then a hold edge ends the pulse.
    add(0, 1, 0, 0, 3'd6, 3'd6, 3'b101, 0);
    add(0, 0, 1, 1, 3'd0, 3'd7, 3'b100, 0);
`ifdef COUNTER_SATURATE_EN
    add(0, 0, 1, 1, 3'd0, 3'd7, 3'b100, 1);
    add(0, 0, 1, 1, 3'd0, 3'd7, 3'b100, 1);
    add(0, 0, 0, 1, 3'd0, 3'd7, 3'b100, 0);
`else
    add(0, 0, 1, 1, 3'd0, 3'd0, 3'b000, 1);
    add(0, 0, 1, 1, 3'd0, 3'd1, 3'b001, 0);
    add(0, 0, 0, 1, 3'd0, 3'd1, 3'b001, 0);
`endif
    // Direction change mid-count: 1 -> up 2 -> down 1 -> up 2.
    add(0, 1, 0, 0, 3'd1, 3'd1, 3'b001, 0);
    add(0, 0, 1, 1, 3'd0, 3'd2, 3'b011, 0);
    add(0, 0, 1, 0, 3'd0, 3'd1, 3'b001, 0);
    add(0, 0, 1, 1, 3'd0, 3'd2, 3'b011, 0);

    foreach (tbl[i]) apply(1'b0, tbl[i], $sformatf("a%0d", i));

    // MODULUS=6 instance: clamped loads and wrap/saturation at 5 and 0.
    step_b(1, 0, 0, 0, 3'd0, 3'd0, 3'b000, 0, "b_reset");
    step_b(0, 1, 0, 0, 3'd7, 3'd5, 3'b111, 0, "b_load7");
`ifdef COUNTER_SATURATE_EN
    step_b(0, 0, 1, 1, 3'd0, 3'd5, 3'b111, 1, "b_up_top");
`else
    step_b(0, 0, 1, 1, 3'd0, 3'd0, 3'b000, 1, "b_up_top");
`endif
    step_b(0, 1, 0, 0, 3'd3, 3'd3, 3'b010, 0, "b_load3");
    step_b(0, 1, 0, 0, 3'd6, 3'd5, 3'b111, 0, "b_load6");
    step_b(0, 1, 0, 0, 3'd5, 3'd5, 3'b111, 0, "b_load5");
    step_b(0, 1, 0, 0, 3'd0, 3'd0, 3'b000, 0, "b_load0");
`ifdef COUNTER_SATURATE_EN
    step_b(0, 0, 1, 0, 3'd0, 3'd0, 3'b000, 1, "b_down_bot");
    step_b(0, 0, 1, 0, 3'd0, 3'd0, 3'b000, 1, "b_down_again");
`else
    step_b(0, 0, 1, 0, 3'd0, 3'd5, 3'b111, 1, "b_down_bot");
    step_b(0, 0, 1, 0, 3'd0, 3'd4, 3'b110, 0, "b_down_again");
`endif

    idle_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
